// File: rtl/bfis_run_harness_if.sv
// ---------------------------------------------------------------------------
// bfis_run_harness_if
// Engine-side bundle between the run harness and the best-first search engine.
//   tick_out       harness -> engine  clock enable
//   eng_start_out  harness -> engine  one-cycle start strobe
//   eng_query_out  harness -> engine  captured query vector (DIM*DATA_WIDTH)
//   eng_k_out      harness -> engine  captured result count (K_WIDTH)
//   eng_valid_in   engine -> harness  result valid, honoured on tick cycles
//   eng_data_in    engine -> harness  result word (DATA_WIDTH)
// master = harness side, slave = engine side.
// ---------------------------------------------------------------------------
interface bfis_run_harness_if #(
  parameter int DIM        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int K_WIDTH    = 16
);
  logic                      tick_out;
  logic                      eng_start_out;
  logic [DIM*DATA_WIDTH-1:0] eng_query_out;
  logic [K_WIDTH-1:0]        eng_k_out;
  logic                      eng_valid_in;
  logic [DATA_WIDTH-1:0]     eng_data_in;

  modport master (
    output tick_out, eng_start_out, eng_query_out, eng_k_out,
    input  eng_valid_in, eng_data_in
  );

  modport slave (
    input  tick_out, eng_start_out, eng_query_out, eng_k_out,
    output eng_valid_in, eng_data_in
  );
endinterface

// File: rtl/bfis_run_harness.sv
// ---------------------------------------------------------------------------
// bfis_run_harness
// Run controller and result buffer between the host debug core and the
// best-first search engine. Captures query/k on go_in, strobes the engine
// once on the first tick, gates the engine with a tick enable and collects k
// results into a show-ahead FIFO that the host drains one entry per rising
// edge of deq_req_in.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-low reset
//   go_in, k_in, query_in start pulse with sampled k and query vector
//   eng                   engine bundle (bfis_run_harness_if.master)
//   deq_req_in            level dequeue request (rising edge dequeues)
//   data_out, valid_out   FIFO head (0 when empty), FIFO not empty
//   count_out             FIFO occupancy
//   full_out, empty_out   FIFO status
//   busy_out, done_out    run in progress (ARM/RUN), run complete (DONE)
//   drop_count_out        results lost to a full FIFO (saturating)
//
// Build option: define BFIS_DROP_COUNT_EN to implement drop_count_out;
// otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module bfis_run_harness #(
  parameter int DIM        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int K_WIDTH    = 16,
  parameter int DEPTH      = 8,
  parameter int TICK_LOG2  = 20
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       go_in,
  input  logic [K_WIDTH-1:0]         k_in,
  input  logic [DIM*DATA_WIDTH-1:0]  query_in,
  bfis_run_harness_if.master         eng,
  input  logic                       deq_req_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic [15:0]                drop_count_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t                    state_r, state_next;
  logic                      tick;
  logic                      start;
  logic                      capture;
  logic [DIM*DATA_WIDTH-1:0] query_r;
  logic [K_WIDTH-1:0]        k_r;
  logic [K_WIDTH-1:0]        res_cnt_r;
  logic                      enq_try, enq, deq;
  logic                      deq_prev_r;
  logic [AW-1:0]             wr_ptr_r, rd_ptr_r;
  logic [AW:0]               count_r;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  // Tick generator: free-running counter, tick on all-ones; constant when period is 1.
  generate
    if (TICK_LOG2 == 0) begin : g_tick_const
      assign tick = 1'b1;
    end else begin : g_tick_cnt
      logic [TICK_LOG2-1:0] tick_cnt_r;
      // Free-running tick counter.
      always_ff @(posedge clk_in) begin
        if (!rst_in) tick_cnt_r <= '0;
        else         tick_cnt_r <= tick_cnt_r + TICK_LOG2'(1);
      end
      assign tick = &tick_cnt_r;
    end
  endgenerate

  assign enq_try  = (state_r == RUN) && tick && eng.eng_valid_in;
  assign empty_out = (count_r == '0);
  assign full_out  = (count_r == (AW+1)'(DEPTH));
  // Only a fresh rising edge of the request dequeues; edges while empty are lost.
  assign deq       = deq_req_in && !deq_prev_r && !empty_out;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign enq       = enq_try && (!full_out || deq);

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state_r <= IDLE;
    else         state_r <= state_next;
  end

  // FSM next-state and strobes.
  always_comb begin
    state_next = state_r;
    start      = 1'b0;
    capture    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (go_in) begin
          capture    = 1'b1;
          state_next = (k_in != '0) ? ARM : DONE;
        end else begin
          state_next = state_r;
        end
      end
      ARM: begin
        if (tick) begin
          start      = 1'b1;
          state_next = RUN;
        end else begin
          state_next = ARM;
        end
      end
      RUN: begin
        if (enq_try && ((res_cnt_r + K_WIDTH'(1)) == k_r)) state_next = DONE;
        else                                              state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run parameters and result counter; rejected results still count toward k.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      query_r   <= '0;
      k_r       <= '0;
      res_cnt_r <= '0;
    end else if (capture) begin
      query_r   <= query_in;
      k_r       <= k_in;
      res_cnt_r <= '0;
    end else if (enq_try) begin
      res_cnt_r <= res_cnt_r + K_WIDTH'(1);
    end
  end

  // FIFO pointers, occupancy and request-edge history (history resets high).
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      deq_prev_r <= 1'b1;
    end else begin
      deq_prev_r <= deq_req_in;
      if (enq) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({enq, deq})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the pointers, so no reset.
  always_ff @(posedge clk_in) begin
    if (enq) mem[wr_ptr_r] <= eng.eng_data_in;
  end

`ifdef BFIS_DROP_COUNT_EN
  logic [15:0] drop_cnt_r;
  // Saturating count of results rejected by a full FIFO.
  always_ff @(posedge clk_in) begin
    if (!rst_in)                                         drop_cnt_r <= 16'h0000;
    else if (enq_try && !enq && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'h0001;
  end
  assign drop_count_out = drop_cnt_r;
`else
  assign drop_count_out = 16'h0000;
`endif

  assign data_out          = empty_out ? '0 : mem[rd_ptr_r];
  assign valid_out         = !empty_out;
  assign count_out         = count_r;
  assign busy_out          = (state_r == ARM) || (state_r == RUN);
  assign done_out          = (state_r == DONE);
  assign eng.tick_out      = tick;
  assign eng.eng_start_out = start;
  assign eng.eng_query_out = query_r;
  assign eng.eng_k_out     = k_r;

endmodule
